// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle of hazard/stall signals exchanged between the five-
//               stage pipeline datapath and its pipeline controller.
//               master : datapath side (drives hazard info, receives enables)
//               slave  : controller side (pipe_ctrl)
//               Hazard inputs : rs_ID, rt_ID, uses_rt_ID, MemRead_EX, Wreg_EX,
//                               Branch_taken_EX, Jump_ID, mem_req_MEM,
//                               mem_ready
//               Control outs  : pc_en, if_id_en, id_ex_en, ex_mem_en,
//                               mem_wb_en, if_id_clr, id_ex_clr, ex_mem_clr,
//                               mem_wb_clr, mem_timeout, stall_cycles
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic [4:0]  rs_ID;
    logic [4:0]  rt_ID;
    logic        uses_rt_ID;
    logic        MemRead_EX;
    logic [4:0]  Wreg_EX;
    logic        Branch_taken_EX;
    logic        Jump_ID;
    logic        mem_req_MEM;
    logic        mem_ready;

    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_clr;
    logic        id_ex_clr;
    logic        ex_mem_clr;
    logic        mem_wb_clr;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    modport master (
        output rs_ID, rt_ID, uses_rt_ID, MemRead_EX, Wreg_EX,
               Branch_taken_EX, Jump_ID, mem_req_MEM, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr,
               mem_timeout, stall_cycles
    );

    modport slave (
        input  rs_ID, rt_ID, uses_rt_ID, MemRead_EX, Wreg_EX,
               Branch_taken_EX, Jump_ID, mem_req_MEM, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr,
               mem_timeout, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Stall/flush controller for a five-stage pipeline. Resolves
//               memory waits, taken branches, load-use hazards and jumps
//               into per-stage load-enable and bubble-insert controls, with
//               a memory-wait watchdog and a saturating stall counter.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - pipe_ctrl_if.slave (hazard inputs, stage controls,
//                      mem_timeout flag, stall_cycles counter)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl (
    input  wire logic  clk,
    input  wire logic  rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Number of WAIT cycles tolerated before declaring a memory timeout.
    localparam logic [7:0]  WAIT_LIMIT = 8'd255;
    localparam logic [15:0] STALL_MAX  = 16'hFFFF;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_q, stall_d;

    logic mem_wait;
    logic load_use;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        mem_wait = bus.mem_req_MEM & ~bus.mem_ready;
        // r0 is hard-wired zero, so a load targeting it never creates a hazard.
        load_use = bus.MemRead_EX && (bus.Wreg_EX != 5'd0) &&
                   ((bus.Wreg_EX == bus.rs_ID) ||
                    (bus.uses_rt_ID && (bus.Wreg_EX == bus.rt_ID)));
    end

    // ------------------------------------------------------------------
    // Stage controls: priority ERR > memory wait > branch > load-use > jump
    // ------------------------------------------------------------------
    always_comb begin
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        id_ex_en   = 1'b1;
        ex_mem_en  = 1'b1;
        mem_wb_en  = 1'b1;
        if_id_clr  = 1'b0;
        id_ex_clr  = 1'b0;
        ex_mem_clr = 1'b0;
        mem_wb_clr = 1'b0;

        if (!rst || (state_q == ST_ERR)) begin
            // Freeze everything: during reset and after a memory timeout.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (mem_wait) begin
            // Hold the front of the pipe; WB receives a bubble meanwhile.
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_clr = 1'b1;
        end else if (bus.Branch_taken_EX) begin
            // Squash the two younger instructions (also kills any load-use).
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID one cycle and send a bubble into EX.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
        end else if (bus.Jump_ID) begin
            if_id_clr = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state, wait watchdog and stall counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_WAIT: begin
                if (!mem_wait) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_q == (WAIT_LIMIT - 8'd1)) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase

        stall_d = stall_q;
        if (!pc_en && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            stall_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.id_ex_en     = id_ex_en;
    assign bus.ex_mem_en    = ex_mem_en;
    assign bus.mem_wb_en    = mem_wb_en;
    assign bus.if_id_clr    = if_id_clr;
    assign bus.id_ex_clr    = id_ex_clr;
    assign bus.ex_mem_clr   = ex_mem_clr;
    assign bus.mem_wb_clr   = mem_wb_clr;
    // ERR is only left through reset, so the state itself is the sticky flag.
    assign bus.mem_timeout  = (state_q == ST_ERR);
    assign bus.stall_cycles = stall_q;

endmodule
`default_nettype wire
